// File: rtl/cancid_ctx_engine.sv
// Per-stream DFA context manager between the packet parser and one DFA matcher.
// Saves/restores DFA state per stream and keeps saturating match counters.
module cancid_ctx_engine #(
  parameter int STATE_W  = 11,
  parameter int SID_W    = 6,
  parameter int COUNT_W  = 16,
  parameter int PIPE_LAT = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_state,
  input  logic [SID_W-1:0]   stream_id,
  input  logic [7:0]         char_in,
  input  logic               char_in_vld,
  input  logic               eop,
  input  logic               enable,
  input  logic               clr_stream,
  input  logic [SID_W-1:0]   clr_id,
  input  logic [SID_W-1:0]   rd_id,
  output logic [COUNT_W-1:0] rd_count,
  output logic [COUNT_W-1:0] total_count,
  output logic               fired,
  output logic               pkt_done,
  output logic               pkt_matched,
  output logic               load_err,
  output logic [7:0]         dfa_char,
  output logic               dfa_char_vld,
  output logic [STATE_W-1:0] dfa_state_in,
  output logic               dfa_state_in_vld,
  input  logic [STATE_W-1:0] dfa_state_out,
  input  logic               dfa_accept
);

  localparam int NS = 2**SID_W;
  localparam int DW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
  localparam logic [COUNT_W-1:0] CMAX = '1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, COMMIT} st_t;

  st_t                st;
  logic [SID_W-1:0]   cur_sid;
  logic               en_lat;
  logic               dfa_accept_r;
  logic [STATE_W-1:0] st_r;
  logic [DW-1:0]      dcnt;
  logic [NS-1:0]      valid;
  logic [COUNT_W-1:0] cnt [NS];
  logic [STATE_W-1:0] mem [NS];

  logic               commit_wr;
  logic [STATE_W-1:0] restore;

  assign commit_wr = (st == COMMIT) && en_lat;

  // Same-cycle clear beats forwarding; forwarding beats the stale memory.
  always_comb begin
    restore = '0;
    if (clr_stream && clr_id == stream_id)
      restore = '0;
    else if (commit_wr && stream_id == cur_sid)
      restore = st_r;
    else if (valid[stream_id])
      restore = mem[stream_id];
  end

  always_ff @(posedge clk) begin
    if (commit_wr)
      mem[cur_sid] <= st_r;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st               <= IDLE;
      cur_sid          <= '0;
      en_lat           <= 1'b0;
      dfa_accept_r     <= 1'b0;
      st_r             <= '0;
      dcnt             <= '0;
      valid            <= '0;
      for (int i = 0; i < NS; i++)
        cnt[i] <= '0;
      total_count      <= '0;
      rd_count         <= '0;
      fired            <= 1'b0;
      pkt_done         <= 1'b0;
      pkt_matched      <= 1'b0;
      load_err         <= 1'b0;
      dfa_char         <= '0;
      dfa_char_vld     <= 1'b0;
      dfa_state_in     <= '0;
      dfa_state_in_vld <= 1'b0;
    end else begin
      dfa_state_in_vld <= 1'b0;
      dfa_char_vld     <= 1'b0;
      pkt_done         <= 1'b0;
      pkt_matched      <= 1'b0;
      load_err         <= 1'b0;
      dfa_accept_r     <= dfa_accept;
      dfa_char         <= char_in;
      rd_count         <= cnt[rd_id];
      if ((st == RUN || st == DRAIN) && dfa_accept_r)
        fired <= 1'b1;
      unique case (st)
        IDLE: begin
          if (load_state) begin
            cur_sid          <= stream_id;
            fired            <= 1'b0;
            dfa_state_in     <= restore;
            dfa_state_in_vld <= 1'b1;
            st               <= RUN;
          end
        end
        RUN: begin
          dfa_char_vld <= char_in_vld;
          load_err     <= load_state;
          if (eop) begin
            en_lat <= enable;
            dcnt   <= '0;
            st     <= DRAIN;
          end
        end
        DRAIN: begin
          load_err <= load_state;
          st_r     <= dfa_state_out;
          // pkt_done is timed to coincide with the COMMIT cycle
          if (dcnt == DW'(PIPE_LAT - 1)) begin
            st          <= COMMIT;
            pkt_done    <= 1'b1;
            pkt_matched <= en_lat & (fired | dfa_accept_r);
          end else begin
            dcnt <= dcnt + 1'b1;
          end
        end
        COMMIT: begin
          fired <= 1'b0;
          if (en_lat) begin
            valid[cur_sid] <= 1'b1;
            if (fired && cnt[cur_sid] != CMAX)
              cnt[cur_sid] <= cnt[cur_sid] + 1'b1;
            if (fired && total_count != CMAX)
              total_count <= total_count + 1'b1;
          end
          if (load_state) begin
            cur_sid          <= stream_id;
            dfa_state_in     <= restore;
            dfa_state_in_vld <= 1'b1;
            st               <= RUN;
          end else begin
            st <= IDLE;
          end
        end
        default: st <= IDLE;
      endcase
      if (clr_stream) begin
        valid[clr_id] <= 1'b0;
        cnt[clr_id]   <= '0;
      end
    end
  end

endmodule

// File: tb/tb_cancid_ctx_engine.sv
// Directed bench for cancid_ctx_engine with a small DFA model and scoreboard.
// Restored states and match results are queued at stimulus and popped on output.
module tb_cancid_ctx_engine;

  localparam int SW = 11;
  localparam int IW = 6;
  localparam int CW = 2;
  localparam int PL = 3;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          load_state;
  logic [IW-1:0] stream_id;
  logic [7:0]    char_in;
  logic          char_in_vld;
  logic          eop;
  logic          enable;
  logic          clr_stream;
  logic [IW-1:0] clr_id;
  logic [IW-1:0] rd_id;
  logic [CW-1:0] rd_count;
  logic [CW-1:0] total_count;
  logic          fired;
  logic          pkt_done;
  logic          pkt_matched;
  logic          load_err;
  logic [7:0]    dfa_char;
  logic          dfa_char_vld;
  logic [SW-1:0] dfa_state_in;
  logic          dfa_state_in_vld;
  logic [SW-1:0] dfa_state_out;
  logic          dfa_accept;

  always #5 clk = ~clk;

  cancid_ctx_engine #(
    .STATE_W(SW), .SID_W(IW), .COUNT_W(CW), .PIPE_LAT(PL)
  ) dut (
    .clk(clk), .rst(rst),
    .load_state(load_state), .stream_id(stream_id),
    .char_in(char_in), .char_in_vld(char_in_vld),
    .eop(eop), .enable(enable),
    .clr_stream(clr_stream), .clr_id(clr_id),
    .rd_id(rd_id), .rd_count(rd_count),
    .total_count(total_count), .fired(fired),
    .pkt_done(pkt_done), .pkt_matched(pkt_matched),
    .load_err(load_err),
    .dfa_char(dfa_char), .dfa_char_vld(dfa_char_vld),
    .dfa_state_in(dfa_state_in),
    .dfa_state_in_vld(dfa_state_in_vld),
    .dfa_state_out(dfa_state_out),
    .dfa_accept(dfa_accept)
  );

  // DFA stand-in: state accumulates chars, accept on 0xAA two cycles later
  logic [SW-1:0] d_st = '0;
  logic          d_acc = 1'b0;
  always @(posedge clk) begin
    if (dfa_state_in_vld)
      d_st <= dfa_state_in;
    else if (dfa_char_vld)
      d_st <= d_st + SW'(dfa_char);
    d_acc <= dfa_char_vld && dfa_char == 8'hAA;
  end
  assign dfa_state_out = d_st;
  assign dfa_accept    = d_acc;

  logic [SW-1:0] m_mem [64];
  bit            m_val [64];
  int            m_cnt [64];
  int            m_tot;
  int            cur;
  logic [SW-1:0] run_st;
  bit            run_acc;
  bit            run_en;
  logic [SW-1:0] q_st [$];
  bit            q_m [$];
  logic [SW-1:0] mon_st;
  bit            mon_m;
  int            n_chk = 0;
  int            n_fail = 0;

  always @(negedge clk) begin
    if (!rst && dfa_state_in_vld) begin
      n_chk++;
      assert (q_st.size() > 0) else begin
        n_fail++;
        $error("FAIL restore_unexpected observed %0d expected none", dfa_state_in);
      end
      if (q_st.size() > 0) begin
        mon_st = q_st.pop_front();
        n_chk++;
        assert (dfa_state_in === mon_st) else begin
          n_fail++;
          $error("FAIL restore observed %0d expected %0d", dfa_state_in, mon_st);
        end
      end
    end
    if (!rst && pkt_done) begin
      n_chk++;
      assert (q_m.size() > 0) else begin
        n_fail++;
        $error("FAIL pkt_done_unexpected observed 1 expected 0");
      end
      if (q_m.size() > 0) begin
        mon_m = q_m.pop_front();
        n_chk++;
        assert (pkt_matched === mon_m) else begin
          n_fail++;
          $error("FAIL pkt_matched observed %0b expected %0b", pkt_matched, mon_m);
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic start_pkt(input int sid);
    load_state = 1'b1;
    stream_id  = IW'(sid);
    run_st     = m_val[sid] ? m_mem[sid] : SW'(0);
    q_st.push_back(run_st);
    cur        = sid;
    run_acc    = 1'b0;
    @(negedge clk);
    load_state = 1'b0;
  endtask

  task automatic feed(input int n, input int mask, input bit en);
    logic [7:0] c;
    for (int i = 0; i < n; i++) begin
      c = mask[i] ? 8'hAA : 8'(i + 1);
      char_in     = c;
      char_in_vld = 1'b1;
      eop         = (i == n - 1);
      enable      = en;
      run_st      = run_st + SW'(c);
      if (mask[i]) run_acc = 1'b1;
      if (i == n - 1) begin
        run_en = en;
        q_m.push_back(en && run_acc);
      end
      @(negedge clk);
    end
    char_in_vld = 1'b0;
    eop         = 1'b0;
  endtask

  task automatic finish(input bit clr, input bit chain, input int nsid);
    int k = 0;
    while (pkt_done !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("pkt_done_seen", pkt_done, 1);
    chk("fired", fired, run_acc);
    if (run_en) begin
      m_mem[cur] = run_st;
      m_val[cur] = 1'b1;
      if (run_acc) begin
        if (m_cnt[cur] < CMAX) m_cnt[cur]++;
        if (m_tot < CMAX) m_tot++;
      end
    end
    if (clr) begin
      clr_stream = 1'b1;
      clr_id     = IW'(cur);
      m_val[cur] = 1'b0;
      m_cnt[cur] = 0;
    end
    if (chain) start_pkt(nsid);
    else @(negedge clk);
    clr_stream = 1'b0;
  endtask

  task automatic chk_cnt(input int sid);
    rd_id = IW'(sid);
    @(negedge clk);
    chk("rd_count", rd_count, m_cnt[sid]);
    chk("total_count", total_count, m_tot);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) begin
      m_val[i] = 1'b0;
      m_cnt[i] = 0;
    end
    m_tot = 0;
  endtask

  initial begin
    rst = 1'b1;
    load_state = 0; stream_id = 0; char_in = 0; char_in_vld = 0;
    eop = 0; enable = 0; clr_stream = 0; clr_id = 0; rd_id = 0;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_fired", fired, 0);
    chk("rst_pkt_done", pkt_done, 0);
    chk("rst_load_err", load_err, 0);
    chk("rst_total", total_count, 0);
    chk("rst_rd_count", rd_count, 0);
    chk("rst_char_vld", dfa_char_vld, 0);
    chk("rst_state_vld", dfa_state_in_vld, 0);

    // new stream, no accept
    start_pkt(5); feed(4, 'b0000, 1); finish(0, 0, 0); chk_cnt(5);
    // two accepts, one count
    start_pkt(5); feed(5, 'b01010, 1); finish(0, 0, 0); chk_cnt(5);
    // disabled regex: no commit
    start_pkt(5); feed(3, 'b001, 0); finish(0, 0, 0); chk_cnt(5);

    // load during RUN is rejected; then back-to-back forwarding
    start_pkt(5);
    load_state = 1'b1; stream_id = 9;
    @(negedge clk);
    load_state = 1'b0;
    chk("load_err_pulse", load_err, 1);
    @(negedge clk);
    chk("load_err_clear", load_err, 0);
    feed(3, 'b100, 1); finish(0, 1, 5);
    feed(2, 'b00, 1); finish(0, 0, 0); chk_cnt(5);

    // async reset mid-packet
    start_pkt(7);
    char_in = 8'h11; char_in_vld = 1'b1;
    repeat (2) @(negedge clk);
    char_in_vld = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    q_st.delete();
    q_m.delete();
    repeat (8) @(negedge clk);
    chk("rst_mid_pkt_done", pkt_done, 0);
    chk_cnt(5);
    start_pkt(5); feed(1, 'b0, 0); finish(0, 0, 0);

    // saturation
    for (int p = 0; p < 4; p++) begin
      start_pkt(3); feed(2, 'b01, 1); finish(0, 0, 0);
    end
    chk_cnt(3);

    // clear colliding with commit of the same stream
    start_pkt(3); feed(2, 'b10, 1); finish(1, 0, 0); chk_cnt(3);
    start_pkt(3); feed(1, 'b0, 1); finish(0, 0, 0);

    // clear of the active stream mid-packet; commit still writes
    start_pkt(3);
    clr_stream = 1'b1; clr_id = 3;
    @(negedge clk);
    clr_stream = 1'b0;
    m_val[3] = 1'b0; m_cnt[3] = 0;
    feed(2, 'b01, 1); finish(0, 0, 0);
    start_pkt(3); feed(2, 'b00, 1); finish(0, 0, 0); chk_cnt(3);

    repeat (4) @(negedge clk);
    chk("restore_q_empty", q_st.size(), 0);
    chk("match_q_empty", q_m.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cancid_ctx_engine.md
Name: cancid_ctx_engine

Overview:
- Parametrised successor of the single-regex cancid wrapper: per-stream DFA context manager sitting between the packet parser and one external DFA matcher.
- Saves and restores DFA state for NUM_STREAMS streams, tracks new streams internally with per-stream valid bits, and keeps saturating per-stream and global match counters.
- Adds a pipeline-aligned EOP commit, same-stream back-to-back forwarding, a stream clear command and a counter read port.

Parameters:
- STATE_W, 11, DFA state width.
- SID_W, 6, stream id width; NUM_STREAMS = 2**SID_W.
- COUNT_W, 16, width of per-stream and global counters; counters saturate.
- PIPE_LAT, 3, cycles from the last char_in_vld until that char's accept is visible as dfa_accept_r.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- load_state  in  1  start of packet; samples stream_id.
- stream_id  in  SID_W  stream of the current packet.
- char_in  in  8  payload byte.
- char_in_vld  in  1  char_in valid.
- eop  in  1  end of packet; may coincide with the last char.
- enable  in  1  regex enabled for this stream; sampled at eop.
- clr_stream  in  1  clear command.
- clr_id  in  SID_W  stream to clear.
- rd_id  in  SID_W  counter read address.
- rd_count  out  COUNT_W  per-stream count of rd_id; 1-cycle latency.
- total_count  out  COUNT_W  global matched-packet count.
- fired  out  1  sticky match flag for the current packet.
- pkt_done  out  1  one-cycle pulse on commit.
- pkt_matched  out  1  valid with pkt_done.
- load_err  out  1  one-cycle pulse when load_state is ignored.
- dfa_char  out  8  registered char to the DFA.
- dfa_char_vld  out  1  registered char valid.
- dfa_state_in  out  STATE_W  restored state.
- dfa_state_in_vld  out  1  state load strobe.
- dfa_state_out  in  STATE_W  DFA current state.
- dfa_accept  in  1  DFA accept.

Behaviour:
- Reset (async):
  - FSM to IDLE.
  - All valid bits, counters, fired, pkt_done, pkt_matched, load_err, dfa_*_vld and rd_count go to 0.
  - State memory is not reset; valid bits gate it.
- FSM states: IDLE, RUN, DRAIN, COMMIT.
- IDLE -> RUN on load_state at cycle t:
  - Latch stream_id as cur_sid and clear fired.
  - At t+1, dfa_state_in = valid[cur_sid] ? mem[cur_sid] : 0, with dfa_state_in_vld pulsed.
- RUN:
  - char_in/char_in_vld are registered to dfa_char/dfa_char_vld; chars are legal from t+1.
  - dfa_accept is registered internally as dfa_accept_r.
  - fired sets when dfa_accept_r=1 in RUN or DRAIN.
- RUN -> DRAIN on eop: latch enable. A char in the eop cycle is processed.
- DRAIN: hold PIPE_LAT cycles, registering dfa_state_out each cycle, then go to COMMIT.
- COMMIT (1 cycle), then IDLE:
  - If enable was latched:
    - mem[cur_sid] = registered dfa_state_out; valid[cur_sid] = 1.
    - count[cur_sid] += fired and total_count += fired, each saturating at 2**COUNT_W-1.
    - pkt_done=1, pkt_matched=fired.
  - Else: no memory or counter update; pkt_done=1, pkt_matched=0.
  - fired clears after COMMIT.
- load_state in COMMIT is accepted and the FSM goes straight to RUN.
  - If stream_id equals cur_sid and the commit writes, the committed state is forwarded to dfa_state_in; the stale memory value is not used.
- load_state in RUN or DRAIN is ignored and load_err pulses.
- char_in_vld and eop outside RUN are ignored.
- clr_stream (any state): valid[clr_id]=0 and count[clr_id]=0 next cycle.
  - Collision with a COMMIT to the same id: clear wins.
  - Clearing the active stream mid-packet: its commit still writes and sets valid.
- rd_count is registered mem-read of count[rd_id]. Reading during a commit to the same id returns the pre-commit value.
- Reset mid-packet: context discarded, no commit, all streams revert to new.

Test Plan:
- Reset, load_state sid=5, chars with no accept, eop enable=1 -> dfa_state_in=0 at t+1; pkt_done with pkt_matched=0; valid[5]=1; rd_count(5)=0.
- Sid=5 packet with dfa_accept twice, enable=1 -> fired=1 once; pkt_matched=1; rd_count(5)=1; total_count=1. Second sid=5 packet restores the saved state.
- Same packet with enable=0 -> pkt_done, pkt_matched=0, counts unchanged, mem[5] unchanged.
- load_state sid=5 in the COMMIT cycle of sid=5 -> dfa_state_in equals the just-committed state. load_state during RUN -> load_err pulse, FSM unaffected.
- COUNT_W=2: four matched packets on sid=3 -> rd_count(3)=3 saturated, total_count=3.
- clr_stream id=3 colliding with COMMIT of sid 3 -> valid[3]=0, count 0. Next load of sid 3 gives dfa_state_in=0. Async rst mid-RUN -> no pkt_done, all counts 0.
